// File: rtl/egret_cfg_seq.sv
// egret_cfg_seq: AXI4-Lite master that replays a fixed register configuration
// sequence after reset (or on start) and reports completion or the failing step.
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESET   clock, synchronous active-high reset
//   start                      one-cycle pulse, re-runs the sequence from DONE/ERR
//   M_AXI_AW*/W*/B*            AXI4-Lite write channels (master side)
//   M_AXI_AR*/R*               AXI4-Lite read channels (master side)
//   seq_done                   sequence completed without error
//   seq_error                  sequence aborted
//   err_code                   {step index[2:0], cause: 0=bad RESP/timeout, 1=readback mismatch}
//
// Build option: define EGRET_CFG_SEQ_READBACK_EN to append the two readback
// steps (0x0C == EXP_VERSION, 0x10 == EXP_VALID); otherwise DONE follows W0x00.
module egret_cfg_seq #(
    parameter int          C_M_AXI_ADDR_WIDTH = 7,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] LED_INIT           = 32'h1,
    parameter logic [31:0] RW_INIT            = 32'h0,
    parameter logic [31:0] EXP_VERSION        = 32'h20220224,
    parameter logic [31:0] EXP_VALID          = 32'h12345678,
    parameter int          TIMEOUT            = 255
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    output logic                            seq_done,
    output logic                            seq_error,
    output logic [3:0]                      err_code
);

`ifdef EGRET_CFG_SEQ_READBACK_EN
    localparam logic RB_EN = 1'b1;
`else
    localparam logic RB_EN = 1'b0;
`endif

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, DONE, ERR} state_t;

    state_t                          r_state;
    logic   [2:0]                    r_step;
    logic                            r_aw_done;
    logic                            r_w_done;
    logic   [7:0]                    r_tmo;
    logic   [3:0]                    r_err;

    state_t                          w_state_nxt;
    state_t                          w_adv_state;
    logic   [2:0]                    w_step_nxt;
    logic   [2:0]                    w_step_inc;
    logic   [2:0]                    w_adv_step;
    logic   [3:0]                    w_err_nxt;
    logic                            w_aw_hs;
    logic                            w_w_hs;
    logic                            w_tmo_hit;
    logic                            w_last;
    logic                            w_is_wr;
    logic                            w_counting;
    logic                            w_rd_ok;
    logic   [C_M_AXI_ADDR_WIDTH-1:0] w_addr;
    logic   [C_M_AXI_DATA_WIDTH-1:0] w_wdata;
    logic   [C_M_AXI_DATA_WIDTH-1:0] w_exp;

    // Step table: three writes (core reset released last), then two readbacks.
    assign w_addr  = r_step == 3'd0 ? C_M_AXI_ADDR_WIDTH'(8'h08) :
                     r_step == 3'd1 ? C_M_AXI_ADDR_WIDTH'(8'h04) :
                     r_step == 3'd2 ? C_M_AXI_ADDR_WIDTH'(8'h00) :
                     r_step == 3'd3 ? C_M_AXI_ADDR_WIDTH'(8'h0C) :
                                      C_M_AXI_ADDR_WIDTH'(8'h10);
    assign w_wdata = r_step == 3'd0 ? C_M_AXI_DATA_WIDTH'(RW_INIT) :
                     r_step == 3'd1 ? C_M_AXI_DATA_WIDTH'(LED_INIT) :
                                      C_M_AXI_DATA_WIDTH'(32'h1);
    assign w_exp   = r_step == 3'd3 ? C_M_AXI_DATA_WIDTH'(EXP_VERSION) :
                                      C_M_AXI_DATA_WIDTH'(EXP_VALID);

    assign w_aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_hs     = M_AXI_WVALID && M_AXI_WREADY;
    assign w_tmo_hit  = r_tmo == TMO_LAST;
    assign w_is_wr    = r_step < 3'd3;
    assign w_last     = (r_step == 3'd4) || (!RB_EN && r_step == 3'd2);
    assign w_step_inc = r_step + 3'd1;
    assign w_adv_state = w_last ? DONE : (w_step_inc < 3'd3 ? WR : RD);
    assign w_adv_step  = w_last ? r_step : w_step_inc;
    assign w_rd_ok    = !RB_EN || (M_AXI_RDATA == w_exp);
    assign w_counting = (r_state == WR) || (r_state == WR_RESP) ||
                        (r_state == RD) || (r_state == RD_DATA);

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: w_state_nxt = w_is_wr ? WR : RD;
            WR: begin
                // AW and W complete independently; leave once both have.
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_nxt = WR_RESP;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ERR;
                    w_err_nxt   = {r_step, 1'b0};
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    w_state_nxt = M_AXI_BRESP == 2'b00 ? w_adv_state : ERR;
                    w_step_nxt  = M_AXI_BRESP == 2'b00 ? w_adv_step : r_step;
                    w_err_nxt   = M_AXI_BRESP == 2'b00 ? r_err : {r_step, 1'b0};
                end else if (w_tmo_hit) begin
                    w_state_nxt = ERR;
                    w_err_nxt   = {r_step, 1'b0};
                end
            end
            RD: begin
                if (M_AXI_ARREADY) begin
                    w_state_nxt = RD_DATA;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ERR;
                    w_err_nxt   = {r_step, 1'b0};
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    if (M_AXI_RRESP != 2'b00) begin
                        w_state_nxt = ERR;
                        w_err_nxt   = {r_step, 1'b0};
                    end else if (!w_rd_ok) begin
                        w_state_nxt = ERR;
                        w_err_nxt   = {r_step, 1'b1};
                    end else begin
                        w_state_nxt = w_adv_state;
                        w_step_nxt  = w_adv_step;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = ERR;
                    w_err_nxt   = {r_step, 1'b0};
                end
            end
            DONE: begin
                w_state_nxt = start ? IDLE : DONE;
                w_step_nxt  = start ? 3'd0 : r_step;
            end
            ERR: begin
                w_state_nxt = start ? IDLE : ERR;
                w_step_nxt  = start ? 3'd0 : r_step;
                w_err_nxt   = start ? 4'd0 : r_err;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_state   <= IDLE;
            r_step    <= 3'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_tmo     <= 8'd0;
            r_err     <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_err     <= w_err_nxt;
            r_aw_done <= (r_state == WR) && (w_state_nxt == WR) && (r_aw_done || w_aw_hs);
            r_w_done  <= (r_state == WR) && (w_state_nxt == WR) && (r_w_done || w_w_hs);
            r_tmo     <= (w_state_nxt != r_state) ? 8'd0 :
                         w_counting ? r_tmo + 8'd1 : r_tmo;
        end
    end

    assign M_AXI_AWVALID = (r_state == WR) && !r_aw_done;
    assign M_AXI_WVALID  = (r_state == WR) && !r_w_done;
    assign M_AXI_AWADDR  = (r_state == WR) ? w_addr : '0;
    assign M_AXI_WDATA   = (r_state == WR) ? w_wdata : '0;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_BREADY  = r_state == WR_RESP;
    assign M_AXI_ARVALID = r_state == RD;
    assign M_AXI_ARADDR  = (r_state == RD) ? w_addr : '0;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = r_state == RD_DATA;
    assign seq_done      = r_state == DONE;
    assign seq_error     = r_state == ERR;
    assign err_code      = r_err;

endmodule

// File: tb/tb_egret_cfg_seq.sv
// tb_egret_cfg_seq: scoreboard bench for egret_cfg_seq with a programmable AXI4-Lite slave.
module tb_egret_cfg_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        seq_done, seq_error;
    logic [3:0]  err_code;

    always #5 clk = ~clk;

    egret_cfg_seq dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .start(start),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .seq_done(seq_done), .seq_error(seq_error), .err_code(err_code)
    );

    int checks = 0;
    int errors = 0;

    // slave behaviour knobs
    bit w_lag4 = 0, aw_block4 = 0, aw_block_all = 0, bad_b = 0, bad_ver = 0, ar_block = 0;

    logic aw_got, w_got;
    int   n_wr, wcnt;

    assign awready = awvalid && !aw_block_all && !(aw_block4 && n_wr == 1);
    assign wready  = wvalid && !(aw_block4 && n_wr == 1) && (wcnt >= ((w_lag4 && n_wr == 1) ? 3 : 0));
    assign arready = arvalid && !ar_block;
    assign rresp   = 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            bvalid <= 1'b0;
            bresp  <= 2'b00;
            rvalid <= 1'b0;
            rdata  <= 32'h0;
            n_wr   <= 0;
            wcnt   <= 0;
        end else begin
            wcnt <= (wvalid && !wready) ? wcnt + 1 : 0;
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                n_wr   <= n_wr + 1;
            end else if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid) begin
                bvalid <= 1'b1;
                bresp  <= (bad_b && n_wr == 2) ? 2'b10 : 2'b00;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got <= aw_got || (awvalid && awready);
                w_got  <= w_got || (wvalid && wready);
            end
            if (rvalid && rready) rvalid <= 1'b0;
            else if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= (araddr == 7'h0C) ? (bad_ver ? 32'h0 : 32'h20220224) : 32'h12345678;
            end
            if (start) n_wr <= 0;
        end
    end

    // scoreboard: {is_read, addr, data}
    logic [39:0] exp_q[$];
    logic [6:0]  obs_a[$], obs_r[$];
    logic [31:0] obs_d[$];
    int          aw_cyc = 0, ar_cyc = 0;
    logic        p_aw = 0, p_w = 0, p_ar = 0;
    logic [6:0]  p_awaddr, p_araddr;
    logic [31:0] p_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_txn(input logic [39:0] got);
        logic [39:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL txn_unexpected: got rd=%0b addr=%h data=%h expected none", got[39], got[38:32], got[31:0]);
        end else begin
            e = exp_q.pop_front();
            if (e !== got) begin
                errors++;
                $display("FAIL txn: got rd=%0b addr=%h data=%h expected rd=%0b addr=%h data=%h",
                         got[39], got[38:32], got[31:0], e[39], e[38:32], e[31:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            p_aw = 0; p_w = 0; p_ar = 0;
        end else begin
            if (p_aw && !seq_error) chk("aw_stable", {awvalid, 24'h0, awaddr}, {1'b1, 24'h0, p_awaddr});
            if (p_w && !seq_error)  chk("w_stable", {wvalid ? wdata : ~p_wdata}, p_wdata);
            if (p_ar && !seq_error) chk("ar_stable", {arvalid, 24'h0, araddr}, {1'b1, 24'h0, p_araddr});
            p_aw = awvalid && !awready; p_awaddr = awaddr;
            p_w  = wvalid && !wready;   p_wdata  = wdata;
            p_ar = arvalid && !arready; p_araddr = araddr;
            if (awvalid) aw_cyc++;
            if (arvalid) ar_cyc++;
            if (awvalid && awready) obs_a.push_back(awaddr);
            if (wvalid && wready) obs_d.push_back(wdata);
            if (arvalid && arready) obs_r.push_back(araddr);
            if (obs_a.size() > 0 && obs_d.size() > 0) cmp_txn({1'b0, obs_a.pop_front(), obs_d.pop_front()});
            if (rvalid && rready) cmp_txn({1'b1, (obs_r.size() > 0) ? obs_r.pop_front() : 7'h7F, rdata});
        end
    end

    task automatic push(input bit rd, input logic [6:0] a, input logic [31:0] d);
        exp_q.push_back({rd, a, d});
    endtask

    task automatic push_writes();
        push(0, 7'h08, 32'h0);
        push(0, 7'h04, 32'h1);
        push(0, 7'h00, 32'h1);
    endtask

    task automatic push_seq();
        push_writes();
`ifdef EGRET_CFG_SEQ_READBACK_EN
        push(1, 7'h0C, 32'h20220224);
        push(1, 7'h10, 32'h12345678);
`endif
    endtask

    task automatic clear_sb();
        exp_q.delete(); obs_a.delete(); obs_d.delete(); obs_r.delete();
        aw_cyc = 0; ar_cyc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_sb();
        @(negedge clk);
        chk("rst_valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_awaddr", {25'h0, awaddr}, 32'h0);
        chk("rst_araddr", {25'h0, araddr}, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_status", {26'h0, seq_done, seq_error, err_code}, 32'h0);
        chk("rst_ties", {21'h0, awprot, arprot, wstrb}, {21'h0, 3'b000, 3'b000, 4'hF});
        rst = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        clear_sb();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        int n = 0;
        while (!(seq_done || seq_error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(seq_done || seq_error)) begin
            errors++;
            $display("FAIL %s_timeout: got no done/error after %0d cycles expected done or error", name, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_end(input string name, input logic d, input logic e, input logic [3:0] c);
        chk({name, "_status"}, {26'h0, seq_done, seq_error, err_code}, {26'h0, d, e, c});
        chk({name, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before 400000");
        $fatal(1, "watchdog");
    end

    initial begin
        // t1: reset values, then automatic run against an always-ready OKAY slave
        do_reset();
        push_seq();
        wait_end("t1", 300);
        chk_end("t1", 1, 0, 4'h0);
        // t2: WREADY three cycles behind AWREADY on the second write
        w_lag4 = 1;
        do_start();
        push_seq();
        wait_end("t2", 300);
        chk_end("t2", 1, 0, 4'h0);
        chk("t2_orphans", obs_a.size() + obs_d.size(), 0);
        w_lag4 = 0;
        // t3: SLVERR on the W0x00 response
        bad_b = 1;
        do_start();
        push_writes();
        wait_end("t3", 300);
        repeat (5) @(negedge clk);
        chk_end("t3", 0, 1, 4'b0100);
        bad_b = 0;
`ifdef EGRET_CFG_SEQ_READBACK_EN
        // t4: version readback mismatch, then a clean rerun
        bad_ver = 1;
        do_start();
        push_writes();
        push(1, 7'h0C, 32'h0);
        wait_end("t4", 300);
        chk_end("t4", 0, 1, 4'b0111);
        bad_ver = 0;
        do_start();
        push_seq();
        wait_end("t4b", 300);
        chk_end("t4b", 1, 0, 4'h0);
        // t5: ARREADY never asserted on the first read
        ar_block = 1;
        do_start();
        push_writes();
        wait_end("t5", 600);
        chk_end("t5", 0, 1, 4'b0110);
        chk("t5_ar_cycles", ar_cyc, 255);
        ar_block = 0;
`endif
        // t6: AWREADY never asserted on the first write
        aw_block_all = 1;
        do_start();
        wait_end("t6", 600);
        chk_end("t6", 0, 1, 4'b0000);
        chk("t6_aw_cycles", aw_cyc, 255);
        aw_block_all = 0;
        // t7: reset while the second write is stalled, sequence restarts at W0x08
        aw_block4 = 1;
        do_start();
        push_seq();
        begin
            int n = 0;
            while (!(awvalid && n_wr == 1) && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t7_reach_step1", {awvalid, 24'h0, awaddr}, {1'b1, 24'h0, 7'h04});
        do_reset();
        aw_block4 = 0;
        push_seq();
        wait_end("t7", 300);
        chk_end("t7", 1, 0, 4'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
